// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, handles stall/flush/branch redirect, and freezes fetch on a HALT opcode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPC = 6'b111111,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 6;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;
    logic            is_halt_word;
    logic            unused_target_lsb;

    assign pc_plus4          = pc_q + XLEN'(4);
    assign target_aligned    = {branch_target[XLEN-1:2], 2'b00};
    assign is_halt_word      = (imem_rdata[XLEN-1:XLEN-OPC_W] == HALT_OPC);
    assign unused_target_lsb = ^branch_target[1:0];

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: branch > flush > stall > normal fetch while running
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_BOOT: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (flush) begin
                    pc_d    = pc_plus4;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = imem_rdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + XLEN'(1);
                    if (is_halt_word) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            S_HALT: begin
                // Only an older in-flight branch can wake fetch back up
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign opcode      = instr_q[XLEN-1:XLEN-OPC_W];
    assign halted      = (state_q == S_HALT);
    assign fetch_count = cnt_q;

endmodule
